// File: rtl/irq_pending_reg.sv
// Eight-line interrupt pending register: synchronises async requests, latches rising edges,
// tracks per-line overflow and flags bad acks. Optional mask port via IRQ_PENDING_MASK_EN.
module irq_pending_reg #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       ack,
   input  logic [2:0] ack_id,
   input  logic       ovf_clr,
`ifdef IRQ_PENDING_MASK_EN
   input  logic [7:0] mask,
`endif
   output logic [7:0] pend,
   output logic       irq_valid,
   output logic [7:0] ovf,
   output logic       ack_err
);

   logic [7:0] sync_last;
   logic [7:0] dly_reg;
   logic [7:0] rise;
   logic [7:0] ack_hit;
   logic [7:0] pending_reg;
   logic [7:0] pending_next;
   logic [7:0] ovf_reg;
   logic [7:0] ovf_next;
   logic       ack_err_reg;
   logic       ack_err_next;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_line
         logic [SYNC_STAGES-1:0] chain_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chain_reg <= '0;
            else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], req[gi]};
         end

         assign sync_last[gi] = chain_reg[SYNC_STAGES-1];
         assign rise[gi]      = sync_last[gi] & ~dly_reg[gi];
         assign ack_hit[gi]   = ack && (ack_id == 3'(gi));

         // A detected edge always wins over a same-cycle ack for the same line.
         assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~ack_hit[gi]);
         assign ovf_next[gi]     = (rise[gi] & pending_reg[gi] & ~ack_hit[gi])
                                 | (ovf_reg[gi] & ~ovf_clr);
      end
   endgenerate

   assign ack_err_next = ack & ~pending_reg[ack_id];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_reg     <= '0;
         pending_reg <= '0;
         ovf_reg     <= '0;
         ack_err_reg <= 1'b0;
      end else begin
         dly_reg     <= sync_last;
         pending_reg <= pending_next;
         ovf_reg     <= ovf_next;
         ack_err_reg <= ack_err_next;
      end
   end

   assign ovf     = ovf_reg;
   assign ack_err = ack_err_reg;

`ifdef IRQ_PENDING_MASK_EN
   // Mask acts only on the outputs so masked lines keep latching and overflowing.
   assign pend      = pending_reg & ~mask;
   assign irq_valid = |pend;
`else
   logic irq_valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_valid_reg <= 1'b0;
      else        irq_valid_reg <= |pending_next;
   end

   assign pend      = pending_reg;
   assign irq_valid = irq_valid_reg;
`endif

endmodule

// File: tb/tb_irq_pending_reg.sv
// Self-checking bench for irq_pending_reg: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_irq_pending_reg;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req = 8'h00;
   logic       ack = 1'b0;
   logic [2:0] ack_id = 3'd0;
   logic       ovf_clr = 1'b0;
   logic [7:0] mask = 8'h00;
   logic [7:0] pend;
   logic       irq_valid;
   logic [7:0] ovf;
   logic       ack_err;

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   irq_pending_reg #(.SYNC_STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .ack       (ack),
      .ack_id    (ack_id),
      .ovf_clr   (ovf_clr),
`ifdef IRQ_PENDING_MASK_EN
      .mask      (mask),
`endif
      .pend      (pend),
      .irq_valid (irq_valid),
      .ovf       (ovf),
      .ack_err   (ack_err)
   );

   // Model: hist[i] is req as sampled i+1 edges before the current one; a line is
   // acted on S edges after its transition is first sampled.
   logic [7:0] hist [0:4];
   logic [7:0] m_pend;
   logic [7:0] m_ovf;
   logic       m_err;

   function automatic logic [7:0] next_pend(input logic [7:0] rs, input logic [7:0] pd,
                                            input logic a, input logic [2:0] id);
      logic [7:0] r;
      r = pd;
      if (a) r[id] = 1'b0;
      return r | rs;
   endfunction

   function automatic logic [7:0] next_ovf(input logic [7:0] rs, input logic [7:0] pd,
                                           input logic [7:0] ov, input logic clr,
                                           input logic a, input logic [2:0] id);
      logic [7:0] r;
      r = clr ? 8'h00 : ov;
      for (int n = 0; n < 8; n++)
         if (rs[n] && pd[n] && !(a && id == 3'(n))) r[n] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) hist[i] <= 8'h00;
         m_pend <= 8'h00;
         m_ovf  <= 8'h00;
         m_err  <= 1'b0;
      end else begin
         hist[0] <= req;
         for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
         m_pend <= next_pend(hist[S-1] & ~hist[S], m_pend, ack, ack_id);
         m_ovf  <= next_ovf(hist[S-1] & ~hist[S], m_pend, m_ovf, ovf_clr, ack, ack_id);
         m_err  <= ack && !m_pend[ack_id];
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_pend", pend, m_pend & ~mask);
         chk("model_irq_valid", {7'd0, irq_valid}, {7'd0, |(m_pend & ~mask)});
         chk("model_ovf", ovf, m_ovf);
         chk("model_ack_err", {7'd0, ack_err}, {7'd0, m_err});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_ack(input logic [2:0] id);
      ack = 1'b1; ack_id = id;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      tick();
      chk("reset_pend", pend, 8'h00);
      chk("reset_ovf", ovf, 8'h00);

      // Single line: visible exactly 3 edges after raise
      req = 8'h01;
      tick(2);
      chk("lat_before", pend, 8'h00);
      tick();
      chk("lat_pend", pend, 8'h01);
      chk("lat_irq", {7'd0, irq_valid}, 8'h01);
      chk("lat_ovf", ovf, 8'h00);
      chk("lat_err", {7'd0, ack_err}, 8'h00);
      do_ack(3'd0);
      tick();
      chk("level_no_reset", pend, 8'h00);
      req = 8'h00;
      tick(2);

      // Two lines together, acked one at a time
      req = 8'h81;
      tick(3);
      chk("two_pend", pend, 8'h81);
      do_ack(3'd7);
      chk("ack7", pend, 8'h01);
      do_ack(3'd0);
      chk("ack0", pend, 8'h00);
      chk("ack0_irq", {7'd0, irq_valid}, 8'h00);
      req = 8'h00;

      // Ack to a non-pending line
      do_ack(3'd5);
      chk("ackerr_pulse", {7'd0, ack_err}, 8'h01);
      chk("ackerr_pend", pend, 8'h00);
      tick();
      chk("ackerr_one", {7'd0, ack_err}, 8'h00);

      // Overflow on line 2, then clear
      req = 8'h04;
      tick(3);
      req = 8'h00;
      tick(2);
      req = 8'h04;
      tick(3);
      chk("ovf_set", ovf, 8'h04);
      chk("ovf_pend", pend, 8'h04);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_clr", ovf, 8'h00);
      do_ack(3'd2);
      req = 8'h00;
      tick(2);

      // Edge on line 3 coincides with ack for line 3
      req = 8'h08;
      tick(3);
      req = 8'h00;
      tick(2);
      req = 8'h08;
      tick(2);
      do_ack(3'd3);
      chk("setwin_pend", pend, 8'h08);
      chk("setwin_ovf", ovf, 8'h00);
      do_ack(3'd3);
      req = 8'h00;
      tick(2);

      // All lines, async reset mid-run, held-high lines after release
      req = 8'hFF;
      tick(3);
      chk("all_pend", pend, 8'hFF);
      rst_n = 1'b0;
      #1;
      chk("async_pend", pend, 8'h00);
      chk("async_irq", {7'd0, irq_valid}, 8'h00);
      chk("async_ovf", ovf, 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("rel_before", pend, 8'h00);
      tick();
      chk("rel_pend", pend, 8'hFF);
`ifdef IRQ_PENDING_MASK_EN
      mask = 8'hF0;
      #1;
      chk("mask_pend", pend, 8'h0F);
      do_ack(3'd7);
      chk("mask_ack_noerr", {7'd0, ack_err}, 8'h00);
      mask = 8'h00;
`endif

      // Randomized phase
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         ack     = ($urandom_range(0, 9) < 3);
         ack_id  = 3'($urandom_range(0, 7));
         ovf_clr = ($urandom_range(0, 19) == 0);
`ifdef IRQ_PENDING_MASK_EN
         mask    = 8'($urandom);
`endif
         rst_n   = ($urandom_range(0, 299) != 0);
         tick();
      end
      ack = 1'b0;
      rst_n = 1'b1;
      tick(2);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
